// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment scanner:
// FSM state encoding, active-low segment patterns and default timing.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int DEFAULT_CLK_DIV   = 50000;
    localparam int DEFAULT_BLANK_CYC = 4;

    // Segment order a..g with a in bit 6; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low one-cold anode pattern for digit position idx.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        anode_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; non-decimal codes stay dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup from digit value to segment pattern.
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Digits are shown one at a time for CLK_DIV cycles, separated by
// BLANK_CYC cycles with every anode off to avoid ghosting. New values are
// staged through a ready/valid port and only reach the display at a frame
// boundary (or immediately while idle), so a frame is never torn.
// Optional build macro SEG7_SCAN_LZB_EN enables leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int BLANK_CYC = DEFAULT_BLANK_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [19:0] DIV_LAST   = 20'(CLK_DIV - 1);
    localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

    scan_state_t state;
    logic [1:0]  idx;
    logic [19:0] cnt;
    logic [15:0] disp;
    logic [15:0] stage;
    logic        pending;
    logic        pending_nxt;
    logic        accept;
    logic        xfer;
    logic [3:0]  cur_digit;
    logic [6:0]  dec_seg;
    logic [6:0]  digit_seg;

    assign accept = load_valid && load_ready;

    // Display takes the staged value at the end of digit 3 or whenever idle.
    assign xfer = (state == ST_IDLE) ||
                  ((state == ST_SHOW) && (idx == 2'd3) && (cnt == DIV_LAST));

    // A new load wins over a transfer so the freshly staged value stays pending.
    always_comb begin
        pending_nxt = pending;
        if (accept) begin
            pending_nxt = 1'b1;
        end else if (xfer) begin
            pending_nxt = 1'b0;
        end
    end

    // Staging / display registers and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= 16'h0000;
            stage      <= 16'h0000;
            pending    <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            if (xfer) begin
                disp <= stage;
            end
            if (accept) begin
                stage <= bcd_in;
            end
            pending    <= pending_nxt;
            load_ready <= !pending_nxt;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        case (idx)
            2'd0:    cur_digit = disp[3:0];
            2'd1:    cur_digit = disp[7:4];
            2'd2:    cur_digit = disp[11:8];
            default: cur_digit = disp[15:12];
        endcase
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef SEG7_SCAN_LZB_EN
    logic lead_zero;

    // A digit is a leading zero when it and everything to its left is zero;
    // digit 0 always shows so a value of zero still reads "0".
    always_comb begin
        case (idx)
            2'd3:    lead_zero = (disp[15:12] == 4'd0);
            2'd2:    lead_zero = (disp[15:8] == 8'd0);
            2'd1:    lead_zero = (disp[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    assign digit_seg = lead_zero ? SEG_BLANK : dec_seg;
`else
    assign digit_seg = dec_seg;
`endif

    // Scan FSM; an/seg are registered to match the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            cnt   <= 20'd0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
        end else begin
            case (state)
                ST_IDLE: begin
                    an  <= AN_OFF;
                    seg <= SEG_BLANK;
                    idx <= 2'd0;
                    cnt <= 20'd0;
                    if (enable) begin
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        idx   <= 2'd0;
                        cnt   <= 20'd0;
                        an    <= AN_OFF;
                        seg   <= SEG_BLANK;
                    end else if (cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= 20'd0;
                        an    <= anode_sel(idx);
                        seg   <= digit_seg;
                    end else begin
                        cnt <= cnt + 20'd1;
                        an  <= AN_OFF;
                        seg <= SEG_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        idx   <= 2'd0;
                        cnt   <= 20'd0;
                        an    <= AN_OFF;
                        seg   <= SEG_BLANK;
                    end else if (cnt == DIV_LAST) begin
                        state <= ST_BLANK;
                        idx   <= idx + 2'd1;
                        cnt   <= 20'd0;
                        an    <= AN_OFF;
                        seg   <= SEG_BLANK;
                    end else begin
                        cnt <= cnt + 20'd1;
                        an  <= anode_sel(idx);
                        seg <= digit_seg;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= 2'd0;
                    cnt   <= 20'd0;
                    an    <= AN_OFF;
                    seg   <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
// A timeline model (position within the scan frame) predicts an/seg/load_ready
// every cycle; hand-computed literals pin the key timing points.
module tb_seg7_scan_ctrl;

    localparam int D = 8;
    localparam int B = 2;
    localparam int F = 4 * (D + B);

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] bcd_in;
    logic        load_valid;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;

    seg7_scan_ctrl #(.CLK_DIV(D), .BLANK_CYC(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fail_prints = 0;

    // Model state: pos = cycles since scanning started, -1 when idle.
    int          pos = -1;
    logic [15:0] disp_m = 16'h0000;
    logic [15:0] stage_m = 16'h0000;
    logic        pend_m = 1'b0;

    logic [6:0] dec_tab [0:15] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                   7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                                   7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     = -1;
            disp_m  = 16'h0000;
            stage_m = 16'h0000;
            pend_m  = 1'b0;
        end else begin
            logic acc;
            logic xf;
            acc = load_valid && !pend_m;
            xf  = (pos < 0) || ((pos % F) == F - 1);
            if (xf) disp_m = stage_m;
            if (acc) begin
                stage_m = bcd_in;
                pend_m  = 1'b1;
            end else if (xf) begin
                pend_m = 1'b0;
            end
            if (!enable) pos = -1;
            else pos = pos + 1;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  ea;
        logic [6:0]  es;
        logic [15:0] sh;
        int p;
        int slot;
        int off;
        ea = 4'hF;
        es = 7'h7F;
        if (pos >= 0) begin
            p    = pos % F;
            slot = p / (D + B);
            off  = p % (D + B);
            if (off >= B) begin
                ea = 4'hF ^ (4'h1 << slot);
                sh = disp_m >> (4 * slot);
                es = dec_tab[sh[3:0]];
`ifdef SEG7_SCAN_LZB_EN
                if (slot > 0 && sh == 16'h0000) es = 7'h7F;
`endif
            end
        end
        checks++;
        if (an === ea && seg === es && load_ready === !pend_m) begin
            passes++;
        end else if (fail_prints < 20) begin
            fail_prints++;
            $display("FAIL model_cmp t=%0t an=%b want %b seg=%b want %b ready=%b want %b",
                     $time, an, ea, seg, es, load_ready, !pend_m);
        end
    end

    int n = 0;
    int t0 = 0;

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic at(input int k);
        while (n < t0 + k) step(1);
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int k;
        k = 0;
        while (an !== target && k < 100) begin
            step(1);
            k++;
        end
        if (an !== target) lit(name, {12'h0, an}, {12'h0, target});
    endtask

    task automatic wait_rdy(input string name);
        int k;
        k = 0;
        while (load_ready !== 1'b1 && k < 100) begin
            step(1);
            k++;
        end
        lit(name, {15'h0, load_ready}, 16'h0001);
    endtask

    task automatic load(input logic [15:0] v);
        bcd_in     = v;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
    endtask

    logic lzb;

    initial begin
`ifdef SEG7_SCAN_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        rst_n      = 1'b0;
        enable     = 1'b0;
        bcd_in     = 16'h0000;
        load_valid = 1'b0;
        step(3);
        lit("reset_an", {12'h0, an}, 16'h000F);
        lit("reset_seg", {9'h0, seg}, 16'h007F);
        lit("reset_ready", {15'h0, load_ready}, 16'h0001);
        rst_n = 1'b1;
        step(1);

        // Load 1234 while idle, then start scanning.
        load(16'h1234);
        lit("idle_load_ready_low", {15'h0, load_ready}, 16'h0000);
        step(1);
        lit("idle_transfer_ready", {15'h0, load_ready}, 16'h0001);
        enable = 1'b1;
        t0 = n;
        at(1);  lit("first_blank_an", {12'h0, an}, 16'h000F);
        at(3);  lit("d0_an", {12'h0, an}, 16'h000E);
                lit("d0_seg", {9'h0, seg}, 16'h004C);
        at(11); lit("gap_an", {12'h0, an}, 16'h000F);
        at(13); lit("d1_an", {12'h0, an}, 16'h000D);
                lit("d1_seg", {9'h0, seg}, 16'h0006);
        at(15); bcd_in = 16'h5678; load_valid = 1'b1;
        at(16); lit("midframe_ready_low", {15'h0, load_ready}, 16'h0000);
                bcd_in = 16'h9999;
        at(23); lit("d2_an", {12'h0, an}, 16'h000B);
                lit("d2_seg_old", {9'h0, seg}, 16'h0012);
        at(33); lit("d3_an", {12'h0, an}, 16'h0007);
                lit("d3_seg_old", {9'h0, seg}, 16'h004F);
        at(40); lit("still_pending", {15'h0, load_ready}, 16'h0000);
        at(41); lit("boundary_ready", {15'h0, load_ready}, 16'h0001);
        at(42); lit("second_accepted", {15'h0, load_ready}, 16'h0000);
                load_valid = 1'b0;
        at(43); lit("new_d0_seg", {9'h0, seg}, 16'h0000);
        at(53); lit("new_d1_seg", {9'h0, seg}, 16'h000F);
        at(83); lit("third_d0_seg", {9'h0, seg}, 16'h0004);

        // Drop enable during digit 2, then restart.
        at(105); lit("d2_before_drop", {12'h0, an}, 16'h000B);
                 enable = 1'b0;
        at(106); lit("drop_dark_an", {12'h0, an}, 16'h000F);
        at(108); enable = 1'b1;
        t0 = n;
        at(2);  lit("restart_blank", {12'h0, an}, 16'h000F);
        at(3);  lit("restart_d0_an", {12'h0, an}, 16'h000E);
                lit("restart_d0_seg", {9'h0, seg}, 16'h0004);

        // Non-decimal digit goes dark with anode still driven.
        load(16'h00A0);
        wait_rdy("a_ready");
        wait_an(4'b1101, "a_wait");
        lit("hexA_seg", {9'h0, seg}, 16'h007F);

        // Leading-zero case.
        load(16'h0040);
        wait_rdy("z_ready");
        wait_an(4'b1110, "z_wait0");
        lit("z_d0", {9'h0, seg}, 16'h0001);
        wait_an(4'b1101, "z_wait1");
        lit("z_d1", {9'h0, seg}, 16'h004C);
        wait_an(4'b1011, "z_wait2");
        lit("z_d2", {9'h0, seg}, lzb ? 16'h007F : 16'h0001);
        wait_an(4'b0111, "z_wait3");
        lit("z_d3", {9'h0, seg}, lzb ? 16'h007F : 16'h0001);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (enable) begin
                if ($urandom_range(0, 299) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
            load_valid = ($urandom_range(0, 19) == 0);
            bcd_in = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bcd_in[15:12] = 4'h0;
                1: bcd_in[15:8] = 8'h00;
                2: bcd_in[15:4] = 12'h000;
                default: ;
            endcase
            step(1);
        end
        load_valid = 1'b0;
        enable = 1'b1;

        // Asynchronous reset during SHOW discards the staged value.
        wait_an(4'b1111, "rst_wait_dark");
        begin
            int k;
            k = 0;
            while (an === 4'b1111 && k < 100) begin
                step(1);
                k++;
            end
        end
        wait_rdy("rst_pre_ready");
        load(16'h9999);
        #2 rst_n = 1'b0;
        #1;
        lit("async_rst_an", {12'h0, an}, 16'h000F);
        lit("async_rst_seg", {9'h0, seg}, 16'h007F);
        lit("async_rst_ready", {15'h0, load_ready}, 16'h0001);
        step(2);
        rst_n = 1'b1;
        t0 = n;
        at(3);
        lit("post_rst_an", {12'h0, an}, 16'h000E);
        lit("post_rst_seg", {9'h0, seg}, 16'h0001);

        step(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
